// File: rtl/m10k_row_unloader.sv
// Drains M result rows from the M10K and serializes each row into DATA_LEN-bit words on a valid/ready stream.
// Optional word checksum on o_sum when M10K_UNLOAD_SUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for i_start; address parked
// ADDR    | address driven, waiting RD_LAT cycles for read data
// CAPTURE | latch the row from the read port
// SEND    | stream words of the latched row, LSB slice first
// DONE    | one-cycle completion pulse
module m10k_row_unloader #(
    parameter int DATA_LEN     = 32,
    parameter int N            = 8,
    parameter int M            = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int OFFSET       = 8,
    parameter int RD_LAT       = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start,
    input  logic [DATA_LEN*N-1:0]     i_read_data,
    output logic [ADDRESS_SIZE-1:0]   o_address,
    output logic [DATA_LEN-1:0]       o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [2:0]                o_state
`ifdef M10K_UNLOAD_SUM_EN
    ,
    output logic [DATA_LEN+5:0]       o_sum
`endif
);

    localparam int WORD_W = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'b111,
        ADDR    = 3'b000,
        CAPTURE = 3'b001,
        SEND    = 3'b010,
        DONE    = 3'b011
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [WORD_W-1:0]       word;
    logic [ROW_W-1:0]        row;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [DATA_LEN*N-1:0]   row_reg;
    logic                    transfer;
    logic                    last_word;
    logic                    last_row;

    assign transfer  = o_valid && i_ready;
    assign last_word = (word == WORD_W'(N - 1));
    assign last_row  = (row == ROW_W'(M - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = ADDR;
            ADDR:    if (wait_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND: begin
                if (transfer && last_word) begin
                    state_nxt = last_row ? DONE : ADDR;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            word      <= '0;
            row       <= '0;
            wait_cnt  <= '0;
            o_address <= ADDRESS_SIZE'(OFFSET);
            row_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        word      <= '0;
                        row       <= '0;
                        wait_cnt  <= WAIT_W'(RD_LAT - 1);
                        o_address <= ADDRESS_SIZE'(OFFSET);
                    end
                end
                ADDR: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                CAPTURE: begin
                    row_reg <= i_read_data;
                    word    <= '0;
                end
                SEND: begin
                    if (transfer) begin
                        if (!last_word) begin
                            word <= word + WORD_W'(1);
                        end else if (!last_row) begin
                            row       <= row + ROW_W'(1);
                            o_address <= o_address + ADDRESS_SIZE'(1);
                            wait_cnt  <= WAIT_W'(RD_LAT - 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef M10K_UNLOAD_SUM_EN
    // Sized so that M*N <= 64 full-scale words cannot overflow.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_sum <= '0;
        end else if (state == IDLE && i_start) begin
            o_sum <= '0;
        end else if (state == SEND && transfer) begin
            o_sum <= o_sum + {6'b0, o_data};
        end
    end
`endif

    assign o_data  = row_reg[word*DATA_LEN +: DATA_LEN];
    assign o_valid = (state == SEND);
    assign o_busy  = (state != IDLE);
    assign o_done  = (state == DONE);
    assign o_state = state;

endmodule

// File: tb/tb_m10k_row_unloader.sv
// Directed bench for m10k_row_unloader: scoreboard of expected words, behavioural M10K read port.
module tb_m10k_row_unloader;
    localparam int DATA_LEN     = 32;
    localparam int N            = 8;
    localparam int M            = 8;
    localparam int ADDRESS_SIZE = 4;
    localparam int OFFSET       = 8;
    localparam int RD_LAT       = 1;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    start = 1'b0;
    logic                    ready = 1'b0;
    logic [DATA_LEN*N-1:0]   read_data;
    logic [ADDRESS_SIZE-1:0] address;
    logic [DATA_LEN-1:0]     data;
    logic                    valid;
    logic                    busy;
    logic                    done;
    logic [2:0]              state;
`ifdef M10K_UNLOAD_SUM_EN
    logic [DATA_LEN+5:0]     sum;
    logic [DATA_LEN+5:0]     exp_sum;
`endif

    logic [DATA_LEN*N-1:0]   mem [2**ADDRESS_SIZE];
    logic [DATA_LEN-1:0]     sb [$];

    int tests = 0;
    int fails = 0;
    int transfers;
    int first_valid_iter;

    m10k_row_unloader #(
        .DATA_LEN(DATA_LEN), .N(N), .M(M), .ADDRESS_SIZE(ADDRESS_SIZE),
        .OFFSET(OFFSET), .RD_LAT(RD_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_read_data (read_data),
        .o_address   (address),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_state     (state)
`ifdef M10K_UNLOAD_SUM_EN
        ,
        .o_sum       (sum)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle read latency memory model.
    always @(posedge clk) read_data <= mem[address];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit ones);
        for (int a = 0; a < 2**ADDRESS_SIZE; a++) mem[a] = '0;
        for (int r = 0; r < M; r++)
            for (int w = 0; w < N; w++)
                mem[OFFSET + r][w*DATA_LEN +: DATA_LEN] = ones ? {DATA_LEN{1'b1}} : DATA_LEN'((r << 8) | w);
    endtask

    task automatic push_expected();
        sb.delete();
`ifdef M10K_UNLOAD_SUM_EN
        exp_sum = '0;
`endif
        for (int r = 0; r < M; r++)
            for (int w = 0; w < N; w++) begin
                sb.push_back(mem[OFFSET + r][w*DATA_LEN +: DATA_LEN]);
`ifdef M10K_UNLOAD_SUM_EN
                exp_sum = exp_sum + {6'b0, mem[OFFSET + r][w*DATA_LEN +: DATA_LEN]};
`endif
            end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        push_expected();
        @(negedge clk);
        start = 1'b0;
        check("start_state_addr", 64'(state), 64'(3'b000));
        check("start_address", 64'(address), 64'(OFFSET));
        check("start_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("capture_state", 64'(state), 64'(3'b001));
        check("capture_valid_low", 64'(valid), 64'd0);
    endtask

    // mode 0: always ready; 1: backpressure; 2: start while busy; 3: stop at row 2 word 3
    task automatic run_unload(input int mode);
        int iter = 0;
        int stall = 0;
        bit prev_stall = 1'b0;
        logic [DATA_LEN-1:0] prev_data = '0;
        logic [DATA_LEN-1:0] exp;
        bit last_seen = 1'b0;
        bit done_seen = 1'b0;
        bit stop = 1'b0;
        transfers = 0;
        first_valid_iter = -1;
        ready = 1'b1;
        while (iter < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (last_seen) begin
                check("done_after_last", 64'(done), 64'd1);
`ifdef M10K_UNLOAD_SUM_EN
                check("sum_at_done", 64'(sum), 64'(exp_sum));
`endif
                done_seen = 1'b1;
                break;
            end
            if (done) check("early_done", 64'(done), 64'd0);
            if (valid && first_valid_iter < 0) first_valid_iter = iter;
            if (prev_stall) begin
                check("stall_valid_held", 64'(valid), 64'd1);
                check("stall_data_held", 64'(data), 64'(prev_data));
            end
            case (mode)
                1: begin
                    if (transfers == 26 && stall < 5) begin
                        ready = 1'b0;
                        stall++;
                        check("bp_data", 64'(data), 64'h0000_0302);
                    end else if (stall >= 5) begin
                        ready = 1'($urandom_range(0, 1));
                    end else begin
                        ready = 1'b1;
                    end
                end
                2: begin
                    ready = 1'b1;
                    if (transfers == 12 && valid) start = 1'b1;
                end
                3: begin
                    ready = 1'b1;
                    if (transfers == 19 && valid) stop = 1'b1;
                end
                default: ready = 1'b1;
            endcase
            if (stop) break;
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    check("extra_transfer", 64'(transfers), 64'(M*N - 1));
                end else begin
                    exp = sb.pop_front();
                    check($sformatf("word_%0d", transfers), 64'(data), 64'(exp));
                end
                transfers++;
                if (sb.size() == 0) last_seen = 1'b1;
            end
            prev_stall = valid && !ready;
            prev_data  = data;
            iter++;
        end
        if (mode != 3 && !done_seen) check("unload_timeout", 64'd0, 64'd1);
        if (mode == 3 && !stop) check("reset_point_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        fill_mem(1'b0);
        rstn = 1'b0;
        #23;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(state), 64'(3'b111));
        check("rst_address", 64'(address), 64'd8);
        check("rst_data", 64'(data), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // full unload with constant ready
        do_start();
        run_unload(0);
        check("first_valid_latency", 64'(first_valid_iter), 64'd0);
        check("full_transfers", 64'(transfers), 64'(M*N));
        @(negedge clk);
        check("post_done_low", 64'(done), 64'd0);
        check("post_done_idle", 64'(state), 64'(3'b111));
        check("post_done_busy", 64'(busy), 64'd0);
        check("post_done_address_held", 64'(address), 64'd15);

        // backpressure then random ready
        do_start();
        run_unload(1);
        check("bp_transfers", 64'(transfers), 64'(M*N));
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // start while busy is ignored
        do_start();
        run_unload(2);
        check("busy_start_transfers", 64'(transfers), 64'(M*N));

        // asynchronous reset in the middle of row 2
        do_start();
        run_unload(3);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_state", 64'(state), 64'(3'b111));
        check("midrst_address", 64'(address), 64'd8);
        @(negedge clk);
        rstn = 1'b1;
        do_start();
        run_unload(0);
        check("after_rst_transfers", 64'(transfers), 64'(M*N));

`ifdef M10K_UNLOAD_SUM_EN
        fill_mem(1'b1);
        do_start();
        run_unload(0);
        check("sum_full_scale", 64'(sum), 64'h3F_FFFF_FFC0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
